// File: rtl/alu_unit_if.sv
// Issue/result handshake bundle for alu_unit.
// master drives requests and consumes results; slave is the ALU.
interface alu_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/alu_unit.sv
// Integer ALU: single-cycle ops plus a shift-add multiplier
// with a one-entry output register and valid/ready handshakes.
module alu_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      clear_in,
  alu_unit_if.slave io
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [XLEN-1:0]  ma, ma_n;
  logic [XLEN-1:0]  mb, mb_n;
  logic [XLEN-1:0]  acc, acc_n;
  logic [TAG_W-1:0] mtag, mtag_n;
  logic             ovld, ovld_n;
  logic [XLEN-1:0]  res, res_n;
  logic [TAG_W-1:0] otag, otag_n;

  logic [XLEN-1:0]  alu_y;
  logic [XLEN-1:0]  mul_acc;
  logic [SW-1:0]    shamt;
  logic             fire;
  logic             out_free;
  logic             is_mul;

  assign io.in_ready = !rst_in && (state == IDLE) && rdy_in
                     && !clear_in && (!ovld || io.out_ready);
  assign io.out_valid  = ovld;
  assign io.out_result = res;
  assign io.out_tag    = otag;
  assign io.busy       = (state == MUL);

  assign fire     = io.in_valid && io.in_ready;
  assign out_free = !ovld || io.out_ready;
  assign is_mul   = (io.in_op == 4'd11);
  assign mul_acc  = acc + (mb[0] ? ma : '0);
  assign shamt    = io.in_b[SW-1:0];

  always_comb begin
    alu_y = '0;
    case (io.in_op)
      4'd0:    alu_y = io.in_a + io.in_b;
      4'd1:    alu_y = io.in_a - io.in_b;
      4'd2:    alu_y = io.in_a & io.in_b;
      4'd3:    alu_y = io.in_a | io.in_b;
      4'd4:    alu_y = io.in_a ^ io.in_b;
      4'd5:    alu_y = io.in_a << shamt;
      4'd6:    alu_y = io.in_a >> shamt;
      4'd7:    alu_y = XLEN'($signed(io.in_a) >>> shamt);
      4'd8:    alu_y = XLEN'($signed(io.in_a) < $signed(io.in_b));
      4'd9:    alu_y = XLEN'(io.in_a < io.in_b);
      4'd10:   alu_y = XLEN'(io.in_a == io.in_b);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ma_n    = ma;
    mb_n    = mb;
    acc_n   = acc;
    mtag_n  = mtag;
    ovld_n  = ovld;
    res_n   = res;
    otag_n  = otag;
    if (clear_in) begin
      state_n = IDLE;
      ovld_n  = 1'b0;
      cnt_n   = '0;
      acc_n   = '0;
    end else begin
      if (ovld && io.out_ready) ovld_n = 1'b0;
      unique case (state)
        IDLE: begin
          if (fire && is_mul) begin
            state_n = MUL;
            ma_n    = io.in_a;
            mb_n    = io.in_b;
            mtag_n  = io.in_tag;
            cnt_n   = CW'(XLEN);
            acc_n   = '0;
          end else if (fire) begin
            ovld_n  = 1'b1;
            res_n   = alu_y;
            otag_n  = io.in_tag;
          end
        end
        MUL: begin
          if (cnt != '0) begin
            acc_n = mul_acc;
            ma_n  = ma << 1;
            mb_n  = mb >> 1;
            cnt_n = cnt - CW'(1);
          end
          // counter==0 here means the product is parked waiting for space
          if ((cnt <= CW'(1)) && out_free) begin
            state_n = IDLE;
            ovld_n  = 1'b1;
            res_n   = (cnt != '0) ? mul_acc : acc;
            otag_n  = mtag;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      mtag  <= '0;
      ovld  <= 1'b0;
      res   <= '0;
      otag  <= '0;
    end else if (rdy_in) begin
      state <= state_n;
      cnt   <= cnt_n;
      ma    <= ma_n;
      mb    <= mb_n;
      acc   <= acc_n;
      mtag  <= mtag_n;
      ovld  <= ovld_n;
      res   <= res_n;
      otag  <= otag_n;
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: vector table, scoreboard,
// and hand-written mul/backpressure/clear/stall/reset sequences.
module tb_alu_unit;
  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;

  alu_unit_if #(.XLEN(32), .TAG_W(4)) io ();

  alu_unit #(.XLEN(32), .TAG_W(4)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .io       (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } sb_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[15];
  int   cmp = 0;
  int   mism = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_op    = op;
    io.in_a     = a;
    io.in_b     = b;
    io.in_tag   = tag;
    #1;
    while (!io.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!io.in_ready) begin
      cmp++;
      mism++;
      $display("FAIL issue_timeout: got in_ready 0 want 1 op %0d", op);
    end else begin
      sb.push_back('{exp, tag});
    end
    @(posedge clk);
    #1 io.in_valid = 1'b0;
  endtask

  // result monitor: pops the scoreboard on every output transfer
  always @(negedge clk) begin
    #2;
    if (!rst_in && rdy_in && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        cmp++;
        mism++;
        $display("FAIL sb_unexpected: got result %h want none",
                 io.out_result);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_result", io.out_result, e.res);
        chk("sb_tag", 32'(io.out_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    int n;
    int bad;
    int seen;

    vt[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 4'd5,  32'h80000000};
    vt[1]  = '{4'd1,  32'h00000000, 32'h00000001, 4'd1,  32'hFFFFFFFF};
    vt[2]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 4'd2,  32'hF000F000};
    vt[3]  = '{4'd3,  32'hF0F0F0F0, 32'h0F0F0000, 4'd3,  32'hFFFFF0F0};
    vt[4]  = '{4'd4,  32'hAAAAAAAA, 32'hFFFF0000, 4'd4,  32'h5555AAAA};
    vt[5]  = '{4'd5,  32'h00000001, 32'h00000021, 4'd6,  32'h00000002};
    vt[6]  = '{4'd6,  32'h80000000, 32'h00000004, 4'd7,  32'h08000000};
    vt[7]  = '{4'd7,  32'h80000000, 32'h00000021, 4'd8,  32'hC0000000};
    vt[8]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 4'd9,  32'h00000001};
    vt[9]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 4'd10, 32'h00000000};
    vt[10] = '{4'd10, 32'h00000005, 32'h00000005, 4'd11, 32'h00000001};
    vt[11] = '{4'd10, 32'h00000005, 32'h00000006, 4'd12, 32'h00000000};
    vt[12] = '{4'd13, 32'h12345678, 32'h00000009, 4'd13, 32'h00000000};
    vt[13] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, 32'h00000000};
    vt[14] = '{4'd7,  32'h7FFFFFFF, 32'h0000001F, 4'd0,  32'h00000000};

    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    clear_in     = 1'b0;
    io.in_valid  = 1'b0;
    io.in_op     = '0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_tag    = '0;
    io.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("rst_result", io.out_result, 32'd0);
    chk("rst_tag", 32'(io.out_tag), 32'd0);
    rst_in = 1'b0;

    // single-cycle ops, back to back, one-cycle latency
    for (int i = 0; i < 15; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);
      chk($sformatf("lat_valid_%0d", i), 32'(io.out_valid), 32'd1);
      chk($sformatf("lat_result_%0d", i), io.out_result, vt[i].exp);
      chk($sformatf("lat_tag_%0d", i), 32'(io.out_tag), 32'(vt[i].tag));
    end

    // multiply: 32 busy cycles with in_ready low
    issue(4'd11, 32'hFFFFFFFF, 32'd3, 4'd9, 32'hFFFFFFFD);
    @(negedge clk);
    n = 0;
    bad = 0;
    while (io.busy && n < 200) begin
      if (io.in_ready) bad++;
      n++;
      @(negedge clk);
    end
    chk("mul_cycles", n, 32);
    chk("mul_in_ready", bad, 0);
    chk("mul_valid", 32'(io.out_valid), 32'd1);
    chk("mul_result", io.out_result, 32'hFFFFFFFD);
    chk("mul_tag", 32'(io.out_tag), 32'd9);

    // backpressure: second add waits, then both drain in order
    @(negedge clk);
    io.out_ready = 1'b0;
    issue(4'd0, 32'd10, 32'd20, 4'd1, 32'd30);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_op    = 4'd1;
    io.in_a     = 32'd100;
    io.in_b     = 32'd1;
    io.in_tag   = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready_low", 32'(io.in_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_held_valid", 32'(io.out_valid), 32'd1);
    chk("bp_held_result", io.out_result, 32'd30);
    io.out_ready = 1'b1;
    sb.push_back('{32'd99, 4'd2});
    #1 chk("bp_in_ready_high", 32'(io.in_ready), 32'd1);
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    chk("bp_second_tag", 32'(io.out_tag), 32'd2);

    // clear during a multiply
    issue(4'd11, 32'd7, 32'd6, 4'd3, 32'd42);
    repeat (10) @(negedge clk);
    clear_in = 1'b1;
    #1 chk("clr_in_ready", 32'(io.in_ready), 32'd0);
    @(negedge clk);
    clear_in = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("clr_busy", 32'(io.busy), 32'd0);
    chk("clr_valid", 32'(io.out_valid), 32'd0);
    chk("clr_in_ready_after", 32'(io.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (io.out_valid) seen++;
    end
    chk("clr_no_result", seen, 0);
    issue(4'd0, 32'd3, 32'd4, 4'd2, 32'd7);
    chk("clr_next_valid", 32'(io.out_valid), 32'd1);
    chk("clr_next_result", io.out_result, 32'd7);

    // rdy_in low for 5 cycles stretches the multiply by 5
    issue(4'd11, 32'h00012345, 32'h00000010, 4'd6, 32'h00123450);
    @(negedge clk);
    n = 0;
    while (io.busy && n < 200) begin
      if (n == 5) rdy_in = 1'b0;
      if (n == 10) rdy_in = 1'b1;
      n++;
      @(negedge clk);
    end
    rdy_in = 1'b1;
    chk("stall_cycles", n, 37);
    chk("stall_result", io.out_result, 32'h00123450);
    chk("stall_tag", 32'(io.out_tag), 32'd6);

    // asynchronous reset mid-multiply
    issue(4'd11, 32'd5, 32'd5, 4'd7, 32'd25);
    repeat (10) @(negedge clk);
    #2 rst_in = 1'b1;
    #1;
    chk("rmid_busy", 32'(io.busy), 32'd0);
    chk("rmid_valid", 32'(io.out_valid), 32'd0);
    chk("rmid_result", io.out_result, 32'd0);
    chk("rmid_tag", 32'(io.out_tag), 32'd0);
    chk("rmid_in_ready", 32'(io.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    void'(sb.pop_back());
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (io.out_valid || io.busy) seen++;
    end
    chk("rmid_no_result", seen, 0);
    issue(4'd4, 32'h0000FFFF, 32'h00FF00FF, 4'd15, 32'h00FFFF00);
    chk("rmid_next_result", io.out_result, 32'h00FFFF00);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
